// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined WIDTH-bit adder/subtractor. Each pipeline stage evaluates
//   GROUPS_PER_STAGE 4-bit carry-lookahead groups. The ripple carry is
//   registered between stages. Finished sum bits and unused operand bits
//   move forward with it. Latency is NSTAGE = WIDTH/(4*GROUPS_PER_STAGE)
//   cycles. The whole pipe advances together under valid/ready flow control.
//
//   Parameters: WIDTH (multiple of 4*GROUPS_PER_STAGE), GROUPS_PER_STAGE.
//   Optional build macro: PIPELINED_CLA_OVF_EN adds the registered signed
//   overflow output ovf.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     in_valid/in_ready operand handshake (in_ready = pipe can advance)
//     a, b, cin, sub    operands; sub=1 computes a-b (cin ignored)
//     out_valid/out_ready result handshake
//     sum, cout         result and carry out of the MSB (sub: 1 = no borrow)
//     ovf               signed overflow (only with PIPELINED_CLA_OVF_EN)
module pipelined_cla_adder #(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_CLA_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int GW     = 4 * GROUPS_PER_STAGE;
    localparam int NSTAGE = WIDTH / GW;

    generate
        if ((GROUPS_PER_STAGE < 1) || (WIDTH < GW) || ((WIDTH % GW) != 0)) begin : g_bad_width
            $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of 4*GROUPS_PER_STAGE");
        end
    endgenerate

    // Returns {carry_out, sum[3:0]} of one 4-bit lookahead group.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Per-stage views: index i is the output of pipeline register i.
    // Stage NSTAGE keeps no operands; res_w[0] is the empty partial sum.
    logic [WIDTH-1:0] opa_w   [0:NSTAGE-1];
    logic [WIDTH-1:0] opb_w   [0:NSTAGE-1];
    logic [WIDTH-1:0] res_w   [0:NSTAGE];
    logic             carry_w [0:NSTAGE];
    logic             valid_w [0:NSTAGE];
    logic             advance;

    assign advance   = ~valid_w[NSTAGE] | out_ready;
    assign in_ready  = advance;
    assign res_w[0]  = '0;

    // Stage 0: operand capture. B is inverted and carry forced to 1 for subtract.
    logic [WIDTH-1:0] a0_reg;
    logic [WIDTH-1:0] b0_reg;
    logic             c0_reg;
    logic             v0_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0_reg <= '0;
            b0_reg <= '0;
            c0_reg <= 1'b0;
            v0_reg <= 1'b0;
        end else if (advance) begin
            v0_reg <= in_valid;
            if (in_valid) begin
                a0_reg <= a;
                b0_reg <= b ^ {WIDTH{sub}};
                c0_reg <= sub | cin;
            end
        end
    end

    assign opa_w[0]   = a0_reg;
    assign opb_w[0]   = b0_reg;
    assign carry_w[0] = c0_reg;
    assign valid_w[0] = v0_reg;

    genvar gi, gj;
    generate
        for (gi = 1; gi <= NSTAGE; gi++) begin : g_stage
            localparam int LO = (gi - 1) * GW;

            logic [GROUPS_PER_STAGE:0] gc;
            logic [GW-1:0]             win_sum;
            logic [WIDTH-1:0]          sum_next;
            logic [WIDTH-1:0]          sum_reg;
            logic                      carry_reg;
            logic                      valid_reg;

            assign gc[0] = carry_w[gi-1];

            for (gj = 0; gj < GROUPS_PER_STAGE; gj++) begin : g_grp
                assign {gc[gj+1], win_sum[4*gj +: 4]} =
                    cla4(opa_w[gi-1][LO + 4*gj +: 4], opb_w[gi-1][LO + 4*gj +: 4], gc[gj]);
            end

            // Lower sum bits pass through; this stage fills in its own window.
            always_comb begin
                sum_next          = res_w[gi-1];
                sum_next[LO +: GW] = win_sum;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_reg   <= '0;
                    carry_reg <= 1'b0;
                    valid_reg <= 1'b0;
                end else if (advance) begin
                    sum_reg   <= sum_next;
                    carry_reg <= gc[GROUPS_PER_STAGE];
                    valid_reg <= valid_w[gi-1];
                end
            end

            assign res_w[gi]   = sum_reg;
            assign carry_w[gi] = carry_reg;
            assign valid_w[gi] = valid_reg;

            if (gi < NSTAGE) begin : g_skew
                logic [WIDTH-1:0] a_reg;
                logic [WIDTH-1:0] b_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_reg <= '0;
                        b_reg <= '0;
                    end else if (advance) begin
                        a_reg <= opa_w[gi-1];
                        b_reg <= opb_w[gi-1];
                    end
                end

                assign opa_w[gi] = a_reg;
                assign opb_w[gi] = b_reg;
            end else begin : g_last
                // Lower operand bits were consumed by earlier stages.
                logic unused_operands;
                assign unused_operands = ^{opa_w[gi-1], opb_w[gi-1]};
`ifdef PIPELINED_CLA_OVF_EN
                // Carry into the MSB is p_msb ^ sum_msb; overflow is that XOR carry out.
                logic ovf_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_reg <= 1'b0;
                    end else if (advance) begin
                        ovf_reg <= opa_w[gi-1][WIDTH-1] ^ opb_w[gi-1][WIDTH-1]
                                 ^ sum_next[WIDTH-1] ^ gc[GROUPS_PER_STAGE];
                    end
                end
                assign ovf = ovf_reg;
`endif
            end
        end
    endgenerate

    assign sum       = res_w[NSTAGE];
    assign cout      = carry_w[NSTAGE];
    assign out_valid = valid_w[NSTAGE];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder
//   Directed bench for pipelined_cla_adder (WIDTH=16, GROUPS_PER_STAGE=1):
//   table of hand-computed vectors, then reset, backpressure and streaming
//   sequences checked against an arithmetic reference.
module tb_pipelined_cla_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PIPELINED_CLA_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .GROUPS_PER_STAGE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPELINED_CLA_OVF_EN
        , .ovf(ovf)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          edge_no;
    } exp_t;

    exp_t exp_q[$];
    exp_t nxt;
    int   ntests = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   pops = 0;
    bit   last_acc;
    bit   last_pop;
    bit   chk_lat = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        ntests++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic c, input logic s);
        exp_t        r;
        logic [15:0] yy;
        logic [16:0] full;
        yy        = s ? ~y : y;
        full      = {1'b0, x} + {1'b0, yy} + (s ? 17'd1 : {16'd0, c});
        r.s       = full[15:0];
        r.co      = full[16];
        r.ov      = (x[15] == yy[15]) && (full[15] != x[15]);
        r.edge_no = 0;
        return r;
    endfunction

    // One clock: observe both handshakes just before the edge, then advance.
    task automatic cycle();
        exp_t e;
        #1;
        last_acc = in_valid && in_ready;
        last_pop = out_valid && out_ready;
        if (last_pop) begin
            if (exp_q.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL spurious: out_valid with sum=%h, required no result", sum);
            end else begin
                e = exp_q.pop_front();
                chk("sum", {16'd0, sum}, {16'd0, e.s});
                chk("cout", {31'd0, cout}, {31'd0, e.co});
`ifdef PIPELINED_CLA_OVF_EN
                chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
                if (chk_lat) chk("latency", cyc - e.edge_no, 4);
                pops++;
                $display("[TB] result sum=%h cout=%0d (exp %h/%0d ov=%0d) cycle %0d",
                         sum, cout, e.s, e.co, e.ov, cyc);
            end
        end
        if (last_acc) begin
            e         = nxt;
            e.edge_no = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 12 && exp_q.size() > 0; t++) cycle();
        if (exp_q.size() != 0) begin
            ntests++;
            nfail++;
            $display("FAIL %s timeout: %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic drive_random();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        nxt = model(a, b, cin, sub);
    endtask

    vec_t        tv[10];
    logic [15:0] held;
    int          sent;
    int          st;

    initial begin
        tv[0] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tv[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tv[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tv[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        tv[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tv[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tv[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tv[8] = '{16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        tv[9] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 0);
        chk("reset_sum", {16'd0, sum}, 0);
        chk("reset_cout", {31'd0, cout}, 0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 1);

        // Directed table, one operation at a time
        for (int i = 0; i < 10; i++) begin
            a   = tv[i].a;
            b   = tv[i].b;
            cin = tv[i].cin;
            sub = tv[i].sub;
            nxt = '{tv[i].s, tv[i].co, tv[i].ov, 0};
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            chk("table_accept", {31'd0, last_acc}, 1);
            drain("table");
        end

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            drive_random();
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 0);
        chk("midreset_sum", {16'd0, sum}, 0);
        chk("midreset_cout", {31'd0, cout}, 0);
        exp_q.delete();
        cycle();
        cycle();
        rst_n = 1'b1;
        #1;
        chk("postreset_in_ready", {31'd0, in_ready}, 1);
        for (int t = 0; t < 10; t++) cycle();
        a = tv[0].a; b = tv[0].b; cin = tv[0].cin; sub = tv[0].sub;
        nxt = '{tv[0].s, tv[0].co, tv[0].ov, 0};
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        drain("postreset");

        // Backpressure: 8 ops back-to-back, 3-cycle stall on the first result
        chk_lat = 1'b0;
        pops = 0;
        sent = 0;
        st   = -1;
        for (int t = 0; t < 40 && (sent < 8 || exp_q.size() > 0); t++) begin
            if (st == -1 && out_valid) begin
                st   = 3;
                held = sum;
            end
            out_ready = !(st > 0);
            in_valid  = (sent < 8);
            drive_random();
            if (st > 0) begin
                #1;
                chk("stall_in_ready", {31'd0, in_ready}, 0);
                chk("stall_out_valid", {31'd0, out_valid}, 1);
                chk("stall_sum_hold", {16'd0, sum}, {16'd0, held});
            end
            cycle();
            if (last_acc) sent++;
            if (st > 0) begin
                st--;
                if (st == 0) st = -2;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_stall_seen", st, -2);
        chk("bp_results", pops, 8);
        drain("backpressure");

        // Throughput: 100 ops on consecutive cycles, latency 4 each
        chk_lat = 1'b1;
        pops = 0;
        for (int i = 0; i < 100; i++) begin
            drive_random();
            in_valid = 1'b1;
            cycle();
            chk("tp_accept", {31'd0, last_acc}, 1);
        end
        in_valid = 1'b0;
        drain("throughput");
        chk("tp_results", pops, 100);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
